game_clock_ctrl: RTL and testbench

- Controller and sequencer for the 4-digit mm:ss BCD game clock that drives the multiplexed 7-segment display.
- Handles start, pause/resume and stop commands, count-up or count-down from a preset, and an expiry pulse.
- Includes an optional level scheduler that raises the game level at a fixed interval.
- Runs entirely in the clk_1HZ domain. Its digits output feeds the display multiplexer.

---
 rtl/game_clock_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_game_clock_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/game_clock_ctrl.sv
// mm:ss BCD game clock sequencer: start/pause/stop, up/down count, expiry pulse.
// Optional level scheduler enabled by defining GAME_CLOCK_LEVEL_SCHED_EN.
module game_clock_ctrl #(
    parameter int LEVEL_SECS = 30,
    parameter int MAX_LEVEL  = 9
) (
    input  logic        clk_1HZ,
    input  logic        reset,
    input  logic        start,
    input  logic        pause,
    input  logic        stop,
    input  logic        mode_down,
    input  logic [15:0] preset_bcd,
    output logic [15:0] digits,
    output logic        running,
    output logic        expired,
    output logic [3:0]  level,
    output logic        level_up
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t      state;
    logic        mode_q;
    logic [15:0] load_val;
    logic [15:0] step_val;
    logic        load_zero;
    logic        load_ev;
    logic        count_ev;

    function automatic logic [15:0] bcd_clamp(input logic [15:0] d);
        logic [15:0] r;
        r[3:0]   = (d[3:0]   > 4'd9) ? 4'd9 : d[3:0];
        r[7:4]   = (d[7:4]   > 4'd5) ? 4'd5 : d[7:4];
        r[11:8]  = (d[11:8]  > 4'd9) ? 4'd9 : d[11:8];
        r[15:12] = (d[15:12] > 4'd5) ? 4'd5 : d[15:12];
        return r;
    endfunction

    function automatic logic [15:0] bcd_inc(input logic [15:0] d);
        logic [15:0] r;
        r = d;
        if (d[3:0] != 4'd9) begin
            r[3:0] = d[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (d[7:4] != 4'd5) begin
                r[7:4] = d[7:4] + 4'd1;
            end else begin
                r[7:4] = 4'd0;
                if (d[11:8] != 4'd9) begin
                    r[11:8] = d[11:8] + 4'd1;
                end else begin
                    r[11:8]  = 4'd0;
                    r[15:12] = (d[15:12] == 4'd5) ? 4'd0 : d[15:12] + 4'd1;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] d);
        logic [15:0] r;
        r = d;
        if (d[3:0] != 4'd0) begin
            r[3:0] = d[3:0] - 4'd1;
        end else begin
            r[3:0] = 4'd9;
            if (d[7:4] != 4'd0) begin
                r[7:4] = d[7:4] - 4'd1;
            end else begin
                r[7:4] = 4'd5;
                if (d[11:8] != 4'd0) begin
                    r[11:8] = d[11:8] - 4'd1;
                end else begin
                    r[11:8]  = 4'd9;
                    r[15:12] = (d[15:12] == 4'd0) ? 4'd5 : d[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    assign load_val  = mode_down ? bcd_clamp(preset_bcd) : 16'h0000;
    assign load_zero = mode_down && (load_val == 16'h0000);
    assign step_val  = mode_q ? bcd_dec(digits) : bcd_inc(digits);
    assign load_ev   = start && !stop && (state == IDLE || state == DONE);
    assign count_ev  = (state == RUN) && !stop && !pause;

    always_ff @(posedge clk_1HZ or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            digits  <= 16'h0000;
            running <= 1'b0;
            expired <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            expired <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (stop) begin
                        state   <= IDLE;
                        digits  <= 16'h0000;
                        running <= 1'b0;
                    end else if (start) begin
                        mode_q <= mode_down;
                        digits <= load_val;
                        // A zero countdown preset expires on the load edge itself
                        if (load_zero) begin
                            state   <= DONE;
                            running <= 1'b0;
                            expired <= 1'b1;
                        end else begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state   <= IDLE;
                        digits  <= 16'h0000;
                        running <= 1'b0;
                    end else if (pause) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end else begin
                        digits <= step_val;
                        if (mode_q && digits == 16'h0001) begin
                            state   <= DONE;
                            running <= 1'b0;
                            expired <= 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (stop) begin
                        state   <= IDLE;
                        digits  <= 16'h0000;
                        running <= 1'b0;
                    end else if (start) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

`ifdef GAME_CLOCK_LEVEL_SCHED_EN
    localparam logic [7:0] LAST_SEC = 8'(LEVEL_SECS - 1);
    localparam logic [3:0] MAX_LVL  = 4'(MAX_LEVEL);

    logic [7:0] sec_cnt;

    always_ff @(posedge clk_1HZ or posedge reset) begin
        if (reset) begin
            sec_cnt  <= 8'd0;
            level    <= 4'd0;
            level_up <= 1'b0;
        end else begin
            level_up <= 1'b0;
            if (stop || load_ev) begin
                sec_cnt <= 8'd0;
                level   <= 4'd0;
            end else if (count_ev) begin
                if (sec_cnt == LAST_SEC) begin
                    sec_cnt <= 8'd0;
                    if (level < MAX_LVL) begin
                        level    <= level + 4'd1;
                        level_up <= 1'b1;
                    end
                end else begin
                    sec_cnt <= sec_cnt + 8'd1;
                end
            end
        end
    end
`else
    logic [13:0] sched_unused;
    assign sched_unused = {8'(LEVEL_SECS), 4'(MAX_LEVEL), load_ev, count_ev};
    assign level        = 4'd0;
    assign level_up     = 1'b0;
`endif

endmodule

// File: tb/tb_game_clock_ctrl.sv
// Directed bench for game_clock_ctrl: vector table plus corner-case sequences.
module tb_game_clock_ctrl;

    logic        clk_1HZ = 1'b0;
    logic        reset;
    logic        start, pause, stop, mode_down;
    logic [15:0] preset_bcd;
    logic [15:0] digits;
    logic        running, expired, level_up;
    logic [3:0]  level;

    int total = 0;
    int bad   = 0;
    int exp_seen;

    game_clock_ctrl #(.LEVEL_SECS(2), .MAX_LEVEL(2)) dut (
        .clk_1HZ(clk_1HZ), .reset(reset),
        .start(start), .pause(pause), .stop(stop),
        .mode_down(mode_down), .preset_bcd(preset_bcd),
        .digits(digits), .running(running), .expired(expired),
        .level(level), .level_up(level_up)
    );

    always #5 clk_1HZ = ~clk_1HZ;

    typedef struct {
        logic        s, p, t, m;
        logic [15:0] pre;
        logic [15:0] d;
        logic        r, e;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, p, t, m,
                                input logic [15:0] pre, d,
                                input logic r, e);
        vec_t v;
        v.s = s; v.p = p; v.t = t; v.m = m;
        v.pre = pre; v.d = d; v.r = r; v.e = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    task automatic step(input logic s, p, t, m, input logic [15:0] pre);
        @(negedge clk_1HZ);
        start = s; pause = p; stop = t; mode_down = m; preset_bcd = pre;
        @(posedge clk_1HZ);
        #1;
        if (expired) exp_seen++;
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    initial begin
        reset = 1'b1;
        start = 0; pause = 0; stop = 0; mode_down = 0; preset_bcd = '0;
        #1;
        chk("reset_outs", {9'd0, digits, running, expired, level, level_up}, 32'd0);
        @(negedge clk_1HZ);
        @(negedge clk_1HZ);
        reset = 1'b0;

        // s p t m preset -> digits running expired
        vecs.push_back(mk(1, 0, 0, 1, 16'h0003, 16'h0003, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0002, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0001, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 16'h0003, 16'h0003, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 16'h7A9F, 16'h5959, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h5958, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 16'h0000, 16'h0000, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 16'h1234, 16'h0000, 1, 0));
        for (int i = 1; i <= 7; i++)
            vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 16'(i), 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 16'h0007, 0, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0007, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0007, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0008, 1, 0));
        vecs.push_back(mk(1, 1, 1, 0, 16'h0000, 16'h0000, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 16'h0010, 16'h0010, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0009, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0008, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0));

        foreach (vecs[i]) begin
            step(vecs[i].s, vecs[i].p, vecs[i].t, vecs[i].m, vecs[i].pre);
            chk($sformatf("vec%0d", i),
                {14'd0, digits, running, expired},
                {14'd0, vecs[i].d, vecs[i].r, vecs[i].e});
        end

        // 12 counting edges in up mode
        exp_seen = 0;
        step(1, 0, 0, 0, 16'h4321);
        for (int i = 0; i < 12; i++) idle_step();
        chk("up12_digits", {16'd0, digits}, 32'h0012);
        chk("up12_running", {31'd0, running}, 32'd1);
        chk("up12_no_exp", exp_seen, 0);

        // full hour wrap in up mode
        step(0, 0, 1, 0, 16'h0000);
        exp_seen = 0;
        step(1, 0, 0, 0, 16'h0000);
        for (int i = 0; i < 3599; i++) idle_step();
        chk("wrap_5959", {16'd0, digits}, 32'h5959);
        idle_step();
        chk("wrap_0000", {16'd0, digits}, 32'h0000);
        chk("wrap_running", {31'd0, running}, 32'd1);
        chk("wrap_no_exp", exp_seen, 0);

        // level scheduler, LEVEL_SECS=2 MAX_LEVEL=2
        step(0, 0, 1, 0, 16'h0000);
        step(1, 0, 0, 0, 16'h0000);
        chk("lvl_load", {27'd0, level, level_up}, 32'd0);
        for (int i = 1; i <= 7; i++) begin
            logic [3:0] el;
            logic       eu;
            idle_step();
`ifdef GAME_CLOCK_LEVEL_SCHED_EN
            el = (i >= 4) ? 4'd2 : (i >= 2) ? 4'd1 : 4'd0;
            eu = (i == 2) || (i == 4);
`else
            el = 4'd0;
            eu = 1'b0;
`endif
            chk($sformatf("lvl_edge%0d", i),
                {27'd0, level, level_up}, {27'd0, el, eu});
        end
        step(0, 0, 1, 0, 16'h0000);
        chk("lvl_stop_clr", {28'd0, level}, 32'd0);

        // asynchronous reset mid-countdown
        step(1, 0, 0, 1, 16'h0035);
        for (int i = 0; i < 5; i++) idle_step();
        chk("rst_pre_0030", {16'd0, digits}, 32'h0030);
        @(negedge clk_1HZ);
        #1 reset = 1'b1;
        #1;
        chk("rst_async", {9'd0, digits, running, expired, level, level_up}, 32'd0);
        @(posedge clk_1HZ);
        #1;
        chk("rst_hold", {9'd0, digits, running, expired, level, level_up}, 32'd0);
        @(negedge clk_1HZ);
        reset = 1'b0;
        idle_step();
        chk("rst_after", {14'd0, digits, running, expired}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
